// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack sequencer: request opcodes, FSM states and stack bounds.
package stack_ctrl_pkg;

    localparam logic [15:0] STACK_TOP   = 16'h0000;
    localparam logic [15:0] STACK_LIMIT = 16'hF000;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEC   = 3'd1,
        ST_WR    = 3'd2,
        ST_RD    = 3'd3,
        ST_CAP   = 3'd4,
        ST_RSP   = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    // PUSH and CALL both store a word; POP and RET both retrieve one.
    function automatic logic is_store_op(input op_t op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack-operation sequencer driving SP strobes and the data-memory port.
// Optional overflow/underflow checking is enabled with `define STACK_CTRL_BOUNDS_EN.
module stack_ctrl
    import stack_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [15:0] req_target,
    input  logic [15:0] sp_val,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_fault,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        busy
);

    state_t      state;
    state_t      state_next;
    op_t         op_q;
    logic [15:0] data_q;
    logic [15:0] target_q;
    logic        accept;
    logic        push_full;
    logic        pop_empty;

`ifdef STACK_CTRL_BOUNDS_EN
    assign push_full = (sp_val == STACK_LIMIT);
    assign pop_empty = (sp_val == STACK_TOP);
    assign rsp_fault = (state == ST_FAULT);
`else
    assign push_full = 1'b0;
    assign pop_empty = 1'b0;
    assign rsp_fault = 1'b0;
`endif

    assign accept = req_valid && req_ready;
    assign busy   = ~req_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Request payload is only meaningful once accepted, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= op_t'(req_op);
            data_q   <= req_data;
            target_q <= req_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rsp_data <= 16'h0000;
        else if (state == ST_CAP)
            rsp_data <= mem_rdata;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        rsp_valid  = 1'b0;
        pc_load    = 1'b0;
        pc_value   = 16'h0000;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_store_op(op_t'(req_op)))
                        state_next = push_full ? ST_FAULT : ST_DEC;
                    else
                        state_next = pop_empty ? ST_FAULT : ST_RD;
                end
            end
            ST_DEC: begin
                sp_dec     = 1'b1;
                state_next = ST_WR;
            end
            // SP has already been decremented by the time we write (full-descending).
            ST_WR: begin
                mem_addr   = sp_val;
                mem_wdata  = data_q;
                mem_we     = 1'b1;
                rsp_valid  = 1'b1;
                if (op_q == OP_CALL) begin
                    pc_load  = 1'b1;
                    pc_value = target_q;
                end
                state_next = ST_IDLE;
            end
            ST_RD: begin
                mem_addr   = sp_val;
                mem_re     = 1'b1;
                state_next = ST_CAP;
            end
            ST_CAP: begin
                sp_inc     = 1'b1;
                state_next = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid  = 1'b1;
                if (op_q == OP_RET) begin
                    pc_load  = 1'b1;
                    pc_value = rsp_data;
                end
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the CPU stack pointer and the data-memory port during stack operations. It accepts one PUSH, POP, CALL or RET request at a time from the control unit. It drives the stack pointer's increment and decrement strobes and issues the memory write or read. On completion it returns popped data or a program-counter load. It sits between the control unit, the SP register, and the shared data-memory port.

## Interface
- STACK_TOP, 16'h0000: SP value when the stack is empty.
- STACK_LIMIT, 16'hF000: SP value when the stack is full.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- req_data  in  16  PUSH: data. CALL: return address.
- req_target  in  16  CALL: jump target.
- sp_val  in  16  current SP.
- sp_inc  out  1  SP increment strobe.
- sp_dec  out  1  SP decrement strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe; data arrives on the next cycle.
- mem_rdata  in  16  memory read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  16  popped word (POP/RET).
- rsp_fault  out  1  overflow or underflow; qualified by rsp_valid.
- pc_load  out  1  PC load strobe (CALL/RET), coincident with rsp_valid.
- pc_value  out  16  PC load value.
- busy  out  1  inverse of req_ready.

## Operation
- Stack is full-descending: push = decrement SP, then write mem[SP]; pop = read mem[SP], then increment SP.
- States and transitions:
  - IDLE: accept on req_valid & req_ready; latch op, data and target. PUSH/CALL go to DEC; POP/RET go to RD.
  - DEC: sp_dec=1; go to WR.
  - WR: mem_addr=sp_val (already decremented), mem_wdata=latched data, mem_we=1, rsp_valid=1. CALL also asserts pc_load=1 with pc_value=latched target. Go to IDLE.
  - RD: mem_addr=sp_val, mem_re=1; go to CAP.
  - CAP: capture mem_rdata into rsp_data; sp_inc=1; go to RSP.
  - RSP: rsp_valid=1. RET also asserts pc_load=1 with pc_value=rsp_data. Go to IDLE.
- Only one request is outstanding. req_ready=1 only in IDLE. Requests presented while busy are held off, not dropped.
- sp_inc and sp_dec are never asserted together.
- This block never writes SP from the bus. The control unit must not write SP while busy=1.
- The response path has no backpressure; rsp_valid is a single pulse.
- SP arithmetic is 16-bit modulo.

## Timing
- Accept on cycle N. PUSH/CALL: sp_dec at N+1, write and rsp_valid at N+2, req_ready again at N+3.
- POP/RET: mem_re at N+1, sp_inc and capture at N+2, rsp_valid at N+3, req_ready again at N+4.
- rsp_data holds its value until the next POP/RET capture.
- Reset values: state IDLE; rsp_data 0; all strobes, rsp_valid, rsp_fault and pc_load 0; mem_addr, mem_wdata and pc_value 0. req_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation abandons the sequence. From the next cycle no strobes are asserted and no response is sent. The SP register shares rst and clears itself.

## Configuration
- STACK_CTRL_BOUNDS_EN defined:
  - PUSH/CALL accepted with sp_val==STACK_LIMIT skips DEC and the write. The block gives rsp_valid=1 and rsp_fault=1 at N+1. CALL with a fault gives no pc_load.
  - POP/RET accepted with sp_val==STACK_TOP skips the read and sp_inc. The block gives rsp_valid=1 and rsp_fault=1 at N+1, with no pc_load. rsp_data is unchanged.
- STACK_CTRL_BOUNDS_EN undefined: no checks are made, SP wraps modulo 2^16, and rsp_fault is tied 0.

## Structure
- Shared package stack_ctrl_pkg holds the op encodings (OP_PUSH, OP_POP, OP_CALL, OP_RET) and the state encodings.
- Single module, no sub-module; a one-hot or binary state register is acceptable.

## Test plan
- SP=0x0000, PUSH 0xBEEF:
  - sp_dec at N+1.
  - mem_we at N+2 with addr 0xFFFF and data 0xBEEF, plus rsp_valid; SP ends at 0xFFFF.
- Then POP:
  - mem_re at addr 0xFFFF, sp_inc.
  - rsp_valid with rsp_data=0xBEEF at N+3; SP ends at 0x0000.
- CALL data 0x0123, target 0x0400, SP=0x0010:
  - writes 0x0123 to 0x000F.
  - pc_load with pc_value=0x0400 at N+2.
  - RET then gives pc_load with pc_value=0x0123 and SP=0x0010.
- With STACK_CTRL_BOUNDS_EN:
  - POP at SP=0x0000 gives rsp_fault=1 at N+1, with no mem_re and no sp_inc.
  - PUSH at SP=0xF000 gives rsp_fault=1, with no write and no sp_dec.
- Back-to-back: req_valid held high with 3 PUSHes is accepted at cycles 0, 3 and 6. busy is high during each sequence.
- rst asserted in the cycle after a POP accept: no sp_inc and no rsp_valid follow; req_ready=1 after rst deasserts.
